alu3_op_scheduler: RTL

//  Shares one 3-bit ALU (ops: add, inverted-add, subtract, 3x3 array multiply) between two requesters.
//  - Round-robin arbitration between the requesters.
//  - Sequences each accepted operation through an EXEC wait of ALU_LAT cycles.
//  - Returns the tagged result on a valid/ready response channel.
//  - Sits between requesting engines and the shared ALU; the ALU itself stays combinational.

---
 rtl/alu3_op_scheduler_if.sv | 40 ++++
 rtl/alu3_op_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu3_op_scheduler_if.sv
// Request/response bundle between two requesting engines and the shared 3-bit ALU scheduler.
// The master side is the requester/consumer; the slave side is the scheduler.
interface alu3_op_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_a;
  logic [2:0]       req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_a;
  logic [2:0]       req1_b;
  logic [1:0]       req1_op;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [1:0]       resp_op;
  logic [5:0]       resp_data;
  logic [CNT_W-1:0] done_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_op, resp_data, done_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_op, resp_data, done_count
  );
endinterface

// File: rtl/alu3_op_scheduler.sv
// Round-robin scheduler sharing one combinational 3-bit ALU between two requesters.
// Each accepted op waits ALU_LAT cycles in EXEC, then is held on the response channel.
module alu3_op_scheduler #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu3_op_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_INV_ADD = 2'b01,
    OP_SUB     = 2'b10,
    OP_MUL     = 2'b11
  } op_t;

  localparam int              LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [2:0]       a_q;
  logic [2:0]       b_q;
  op_t              op_q;
  logic             id_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [5:0]       data_q;
  logic [CNT_W-1:0] done_q;

  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic             exec_last;
  logic             resp_fire;
  logic [5:0]       alu_res;
  logic [5:0]       pp0;
  logic [5:0]       pp1;
  logic [5:0]       pp2;

  // A lone requester wins outright; on a tie the requester not served last time wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt      = state;
    accept         = 1'b0;
    exec_last      = 1'b0;
    resp_fire      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by rst_n so no ready escapes while reset is held with a valid pending.
        if (grant_any && rst_n) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt == LAT_LAST) begin
          exec_last = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // 3x3 array multiplier: one shifted partial-product row per bit of b.
  always_comb begin
    pp0 = {3'b000, a_q & {3{b_q[0]}}};
    pp1 = {2'b00, a_q & {3{b_q[1]}}, 1'b0};
    pp2 = {1'b0, a_q & {3{b_q[2]}}, 2'b00};
    alu_res = '0;
    unique case (op_q)
      OP_ADD:     alu_res = {2'b00, {1'b0, a_q} + {1'b0, b_q}};
      OP_INV_ADD: alu_res = {2'b00, {1'b0, ~a_q} + {1'b0, ~b_q}};
      OP_SUB:     alu_res = {3'b000, a_q - b_q};
      OP_MUL:     alu_res = pp0 + pp1 + pp2;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= 1'b0;
      lat_cnt    <= '0;
      data_q     <= '0;
      done_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (accept) begin
        a_q        <= grant_id ? bus.req1_a : bus.req0_a;
        b_q        <= grant_id ? bus.req1_b : bus.req0_b;
        op_q       <= op_t'(grant_id ? bus.req1_op : bus.req0_op);
        id_q       <= grant_id;
        last_grant <= grant_id;
        lat_cnt    <= '0;
      end else if (state == EXEC) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (exec_last) begin
        data_q <= alu_res;
      end
      if (resp_fire) begin
        done_q <= done_q + 1'b1;
      end
    end
  end

  assign bus.resp_id    = id_q;
  assign bus.resp_op    = op_q;
  assign bus.resp_data  = data_q;
  assign bus.done_count = done_q;

endmodule
